// File: rtl/mips_mem_responder.sv
// Memory-side responder for the MIPS-lite pipeline.
// Serves fetch reads and data loads/stores against a single-port byte-wide
// array, one byte per cycle, big-endian. Data requests win over fetch.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req_valid/ready, if_addr      fetch request handshake and byte address
//   if_rsp_valid, if_rdata           fetch response pulse and word
//   dm_req_valid/ready, dm_we,
//   dm_addr, dm_wdata                data request handshake, store flag, address, store data
//   dm_rsp_valid, dm_rdata           data response pulse and load word (0 on store ack)
//   rsp_err                          current response is for a misaligned address
//   init_we, init_addr, init_byte    image-loader byte write (idle only)
//   busy                             FSM not idle
//   mem_write_status                 one bit per word, set by pipeline stores
module mips_mem_responder #(
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              if_req_valid,
  output logic                              if_req_ready,
  input  logic [ADDR_WIDTH-1:0]             if_addr,
  output logic                              if_rsp_valid,
  output logic [DATA_WIDTH-1:0]             if_rdata,
  input  logic                              dm_req_valid,
  output logic                              dm_req_ready,
  input  logic                              dm_we,
  input  logic [ADDR_WIDTH-1:0]             dm_addr,
  input  logic [DATA_WIDTH-1:0]             dm_wdata,
  output logic                              dm_rsp_valid,
  output logic [DATA_WIDTH-1:0]             dm_rdata,
  output logic                              rsp_err,
  input  logic                              init_we,
  input  logic [ADDR_WIDTH-1:0]             init_addr,
  input  logic [MEM_WIDTH-1:0]              init_byte,
  output logic                              busy,
  output logic [MEM_DEPTH/(DATA_WIDTH/MEM_WIDTH)-1:0] mem_write_status
);

  localparam int unsigned BPI = DATA_WIDTH / MEM_WIDTH;
  localparam int unsigned MA  = $clog2(MEM_DEPTH);
  localparam int unsigned CW  = $clog2(BPI);
  localparam int unsigned WA  = MA - CW;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  req_dm_q;   // 1 = data requester, 0 = fetch
  logic                  we_q;
  logic [WA-1:0]         word_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rbuf_q;
  logic [MEM_WIDTH-1:0]  mem_q [MEM_DEPTH];

  logic                  idle_c;
  logic                  dm_acc_c;
  logic                  if_acc_c;
  logic                  acc_c;
  logic [ADDR_WIDTH-1:0] acc_addr_c;
  logic                  misalign_c;
  logic [MA-1:0]         byte_addr_c;
  logic [MEM_WIDTH-1:0]  rd_byte_c;
  logic [MEM_WIDTH-1:0]  wr_byte_c;
  logic [DATA_WIDTH-1:0] rword_c;
  logic                  unused_bits;

  // Handshake and arbitration: data has fixed priority over fetch.
  assign idle_c       = (state_q == IDLE);
  assign busy         = !idle_c;
  assign dm_req_ready = idle_c;
  assign if_req_ready = idle_c && !dm_req_valid;
  assign dm_acc_c     = idle_c && dm_req_valid;
  assign if_acc_c     = if_req_ready && if_req_valid;
  assign acc_c        = dm_acc_c || if_acc_c;
  assign acc_addr_c   = dm_req_valid ? dm_addr : if_addr;
  assign misalign_c   = (acc_addr_c[CW-1:0] != '0);

  // Base is word-aligned, so the byte counter fills the low address bits.
  assign byte_addr_c = {word_q, cnt_q};
  assign rd_byte_c   = mem_q[byte_addr_c];

  // Upper address bits wrap and are intentionally dropped.
  assign unused_bits = ^{acc_addr_c[ADDR_WIDTH-1:MA], init_addr[ADDR_WIDTH-1:MA]};

  // Big-endian byte lane select: byte k maps to the k-th most significant lane.
  always_comb begin
    rword_c   = rbuf_q;
    wr_byte_c = '0;
    for (int unsigned k = 0; k < BPI; k++) begin
      if (cnt_q == CW'(k)) begin
        rword_c[DATA_WIDTH-1-MEM_WIDTH*k -: MEM_WIDTH] = rd_byte_c;
        wr_byte_c = wdata_q[DATA_WIDTH-1-MEM_WIDTH*k -: MEM_WIDTH];
      end
    end
  end

  // Byte array: pipeline store bytes, else loader writes when idle and unclaimed.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q) begin
      mem_q[byte_addr_c] <= wr_byte_c;
    end else if (idle_c && !acc_c && init_we) begin
      mem_q[init_addr[MA-1:0]] <= init_byte;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      req_dm_q         <= 1'b0;
      we_q             <= 1'b0;
      word_q           <= '0;
      wdata_q          <= '0;
      rbuf_q           <= '0;
      if_rsp_valid     <= 1'b0;
      dm_rsp_valid     <= 1'b0;
      rsp_err          <= 1'b0;
      if_rdata         <= '0;
      dm_rdata         <= '0;
      mem_write_status <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      rsp_err      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acc_c) begin
            req_dm_q <= dm_acc_c;
            we_q     <= dm_acc_c && dm_we;
            word_q   <= acc_addr_c[MA-1:CW];
            wdata_q  <= dm_wdata;
            cnt_q    <= '0;
            if (misalign_c) begin
              // Misaligned: answer immediately with an error, no array access.
              state_q <= RESP;
              rsp_err <= 1'b1;
              if (dm_acc_c) begin
                dm_rsp_valid <= 1'b1;
                dm_rdata     <= '0;
              end else begin
                if_rsp_valid <= 1'b1;
                if_rdata     <= '0;
              end
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          rbuf_q <= rword_c;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(BPI-1)) begin
            state_q <= RESP;
            if (req_dm_q) begin
              dm_rsp_valid <= 1'b1;
              dm_rdata     <= we_q ? '0 : rword_c;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rdata     <= rword_c;
            end
            if (we_q) begin
              mem_write_status[word_q] <= 1'b1;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed self-checking bench for mips_mem_responder.
module tb_mips_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         if_req_valid;
  logic         if_req_ready;
  logic [31:0]  if_addr;
  logic         if_rsp_valid;
  logic [31:0]  if_rdata;
  logic         dm_req_valid;
  logic         dm_req_ready;
  logic         dm_we;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic         dm_rsp_valid;
  logic [31:0]  dm_rdata;
  logic         rsp_err;
  logic         init_we;
  logic [31:0]  init_addr;
  logic [7:0]   init_byte;
  logic         busy;
  logic [1023:0] mem_write_status;

  int checks;
  int failures;
  logic [1023:0] exp_status;

  mips_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata), .rsp_err(rsp_err),
    .init_we(init_we), .init_addr(init_addr), .init_byte(init_byte),
    .busy(busy), .mem_write_status(mem_write_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loader byte write, issued only while the responder is idle.
  task automatic init_wr(input logic [31:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    init_we = 1'b1; init_addr = a; init_byte = b;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // Data request; lat = edges after the accepting edge until the pulse (-1 on timeout).
  task automatic send_dm(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic err,
                         output logic other);
    int n;
    @(negedge clk);
    dm_req_valid = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    n = 0;
    while (!dm_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    dm_req_valid = 1'b0; dm_we = 1'b0;
    lat = 0; other = 1'b0;
    while (!dm_rsp_valid && lat < 20) begin
      other |= if_rsp_valid;
      @(posedge clk); #1; lat++;
    end
    rd = dm_rdata; err = rsp_err; other |= if_rsp_valid;
    if (!dm_rsp_valid) lat = -1;
  endtask

  // Fetch request; same latency convention as send_dm.
  task automatic send_if(input logic [31:0] a, output int lat, output logic [31:0] rd,
                         output logic err, output logic other);
    int n;
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = a;
    n = 0;
    while (!if_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    lat = 0; other = 1'b0;
    while (!if_rsp_valid && lat < 20) begin
      other |= dm_rsp_valid;
      @(posedge clk); #1; lat++;
    end
    rd = if_rdata; err = rsp_err; other |= dm_rsp_valid;
    if (!if_rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic err, oth;
    checks++;
    if ({busy, if_rsp_valid, dm_rsp_valid, rsp_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, if_rsp_valid, dm_rsp_valid, rsp_err});
    end
    checks++;
    if (mem_write_status !== '0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_data: status_nonzero=%b if_rdata=%h dm_rdata=%h expected all 0",
                           |mem_write_status, if_rdata, dm_rdata);
    end
    send_dm(1'b1, 32'h0, 32'h01020304, lat, rd, err, oth);
    send_dm(1'b0, 32'h0, 32'h0, lat, rd, err, oth);
    checks++;
    if (rd !== 32'h01020304 || mem_write_status[0] !== 1'b1) begin
      failures++; $display("FAIL reset_pre_load: got %h status0=%b expected 01020304 status0=1", rd, mem_write_status[0]);
    end
    // Start another load, then pull reset mid-ACCESS between clock edges.
    @(negedge clk);
    while (busy) @(negedge clk);
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
    @(posedge clk); #1; dm_req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, if_rsp_valid, dm_rsp_valid, rsp_err} !== 4'b0000 || mem_write_status !== '0 || dm_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_async: flags=%b status_nonzero=%b dm_rdata=%h expected 0000 0 0",
                           {busy, if_rsp_valid, dm_rsp_valid, rsp_err}, |mem_write_status, dm_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_status = '0;
  endtask

  task automatic test_fetch();
    int lat; logic [31:0] rd; logic err, oth;
    init_wr(32'h10, 8'h8C); init_wr(32'h11, 8'h22);
    init_wr(32'h12, 8'h00); init_wr(32'h13, 8'h04);
    send_if(32'h10, lat, rd, err, oth);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL fetch_latency: got %0d expected 4", lat); end
    checks++;
    if (rd !== 32'h8C220004 || err !== 1'b0) begin
      failures++; $display("FAIL fetch_data: got %h err=%b expected 8c220004 err=0", rd, err);
    end
    checks++;
    if (oth !== 1'b0) begin failures++; $display("FAIL fetch_no_dm_rsp: got %b expected 0", oth); end
    @(posedge clk); #1;
    checks++;
    if (if_rsp_valid !== 1'b0) begin failures++; $display("FAIL fetch_pulse_width: got %b expected 0", if_rsp_valid); end
    checks++;
    if (mem_write_status !== exp_status) begin failures++; $display("FAIL fetch_init_status: got nonzero status expected 0"); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic err, oth;
    send_dm(1'b1, 32'h20, 32'hDEADBEEF, lat, rd, err, oth);
    exp_status[8] = 1'b1;
    checks++;
    if (lat !== 4 || rd !== 32'h0 || err !== 1'b0 || oth !== 1'b0) begin
      failures++; $display("FAIL store_ack: lat=%0d rdata=%h err=%b if_rsp=%b expected 4 00000000 0 0", lat, rd, err, oth);
    end
    checks++;
    if (mem_write_status !== exp_status) begin
      failures++; $display("FAIL store_status: bit8=%b popcount=%0d expected bit8=1 popcount=1",
                           mem_write_status[8], $countones(mem_write_status));
    end
    send_dm(1'b0, 32'h20, 32'h0, lat, rd, err, oth);
    checks++;
    if (lat !== 4 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
      failures++; $display("FAIL load_back: lat=%0d rdata=%h err=%b expected 4 deadbeef 0", lat, rd, err);
    end
  endtask

  task automatic test_arbitration();
    int n;
    @(negedge clk);
    while (busy) @(negedge clk);
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    if_req_valid = 1'b1; if_addr = 32'h10;
    #1;
    checks++;
    if (if_req_ready !== 1'b0 || dm_req_ready !== 1'b1) begin
      failures++; $display("FAIL arb_ready: if_ready=%b dm_ready=%b expected 0 1", if_req_ready, dm_req_ready);
    end
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    n = 0;
    while (!dm_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 4 || dm_rdata !== 32'hDEADBEEF || if_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL arb_dm_first: lat=%0d dm_rdata=%h if_rsp=%b expected 4 deadbeef 0", n, dm_rdata, if_rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (if_req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL arb_if_ready_after: if_ready=%b busy=%b expected 1 0", if_req_ready, busy);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    n = 0;
    while (!if_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 4 || if_rdata !== 32'h8C220004) begin
      failures++; $display("FAIL arb_if_second: lat=%0d if_rdata=%h expected 4 8c220004", n, if_rdata);
    end
  endtask

  task automatic test_misaligned_wrap();
    int lat; logic [31:0] rd; logic err, oth;
    send_dm(1'b0, 32'h22, 32'h0, lat, rd, err, oth);
    // Misaligned response is already visible right after the accepting edge.
    checks++;
    if (lat !== 0 || err !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL misalign_load: lat=%0d err=%b rdata=%h expected 0 1 00000000", lat, err, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_err !== 1'b0 || dm_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL misalign_pulse: err=%b valid=%b expected 0 0", rsp_err, dm_rsp_valid);
    end
    send_dm(1'b1, 32'h21, 32'h55667788, lat, rd, err, oth);
    checks++;
    if (lat !== 0 || err !== 1'b1 || mem_write_status !== exp_status) begin
      failures++; $display("FAIL misalign_store: lat=%0d err=%b status_match=%b expected 0 1 1",
                           lat, err, mem_write_status === exp_status);
    end
    send_dm(1'b0, 32'h20, 32'h0, lat, rd, err, oth);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL misalign_no_write: got %h expected deadbeef", rd); end
    send_dm(1'b0, 32'h1010, 32'h0, lat, rd, err, oth);
    checks++;
    if (lat !== 4 || rd !== 32'h8C220004 || err !== 1'b0) begin
      failures++; $display("FAIL wrap_load: lat=%0d rdata=%h err=%b expected 4 8c220004 0", lat, rd, err);
    end
    send_if(32'h11, lat, rd, err, oth);
    checks++;
    if (lat !== 0 || err !== 1'b1 || rd !== 32'h0 || oth !== 1'b0) begin
      failures++; $display("FAIL misalign_fetch: lat=%0d err=%b rdata=%h dm_rsp=%b expected 0 1 00000000 0", lat, err, rd, oth);
    end
    checks++;
    if (dm_rdata !== 32'h8C220004) begin failures++; $display("FAIL dm_rdata_hold: got %h expected 8c220004", dm_rdata); end
  endtask

  task automatic test_init_ignored();
    int n; int lat; logic [31:0] rd; logic err, oth;
    init_wr(32'h50, 8'h01); init_wr(32'h51, 8'h02);
    init_wr(32'h52, 8'h03); init_wr(32'h53, 8'h04);
    @(negedge clk);
    while (busy) @(negedge clk);
    // Loader writes collide with acceptance, then with ACCESS: both must be dropped.
    dm_req_valid = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    init_we = 1'b1; init_addr = 32'h50; init_byte = 8'hEE;
    @(posedge clk); #1;
    dm_req_valid = 1'b0; init_addr = 32'h51;
    n = 0;
    while (!dm_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    init_we = 1'b0;
    send_dm(1'b0, 32'h50, 32'h0, lat, rd, err, oth);
    checks++;
    if (rd !== 32'h01020304) begin failures++; $display("FAIL init_ignored: got %h expected 01020304", rd); end
    checks++;
    if (mem_write_status !== exp_status) begin failures++; $display("FAIL init_no_status: status changed by loader"); end
  endtask

  task automatic test_reset_mid_store();
    int lat; logic [31:0] rd; logic err, oth; logic seen;
    init_wr(32'h40, 8'hAA); init_wr(32'h41, 8'hBB);
    init_wr(32'h42, 8'hCC); init_wr(32'h43, 8'hDD);
    @(negedge clk);
    while (busy) @(negedge clk);
    dm_req_valid = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h11223344;
    @(posedge clk); #1;
    dm_req_valid = 1'b0; dm_we = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dm_rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midstore_reset: busy=%b valid=%b expected 0 0", busy, dm_rsp_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_status = '0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= dm_rsp_valid; end
    checks++;
    if (seen !== 1'b0 || mem_write_status[16] !== 1'b0) begin
      failures++; $display("FAIL midstore_no_rsp: rsp_seen=%b status16=%b expected 0 0", seen, mem_write_status[16]);
    end
    send_dm(1'b0, 32'h40, 32'h0, lat, rd, err, oth);
    checks++;
    if (rd !== 32'h1122CCDD) begin failures++; $display("FAIL midstore_bytes: got %h expected 1122ccdd", rd); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_status = '0;
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    dm_req_valid = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    init_we = 1'b0; init_addr = '0; init_byte = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset_flags_wrapper();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Reset values are checked while rst_n is still low, then the sequence runs.
  task automatic test_reset_flags_wrapper();
    test_reset_pre();
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    test_fetch();
    test_store_load();
    test_arbitration();
    test_misaligned_wrap();
    test_init_ignored();
    test_reset_mid_store();
  endtask

  task automatic test_reset_pre();
    checks++;
    if (dm_req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle: dm_ready=%b busy=%b expected 1 0", dm_req_ready, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
